// File: rtl/wpu_gen.sv
// Weight pre-processing unit: reduces each incoming weight to its MSR most
// significant bits (or a halved low field) and hands out compensation entries
// from a fixed per-column budget, counting the ones that do not fit.
module wpu_gen #(
  parameter int SIZE     = 8,
  parameter int MSR      = 4,
  parameter int COMP_W   = 3,
  parameter int MAX_COMP = 3,
  localparam int W   = 2 * MSR,
  localparam int AW  = $clog2(SIZE * SIZE),
  localparam int RW  = $clog2(SIZE),
  localparam int CAW = $clog2(SIZE * MAX_COMP),
  localparam int DW  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      weight_in,
  input  logic [AW-1:0]     addr_in,
  input  logic              cfg_no_comp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MSR:0]      reduced_w,
  output logic [AW-1:0]     addr_out,
  output logic              comp_valid,
  output logic [COMP_W-1:0] comp_w,
  output logic [RW-1:0]     comp_row,
  output logic [CAW-1:0]    comp_addr,
  output logic [DW-1:0]     drop_cnt,
  output logic              col_done
);

  // Budget counter must be able to hold MAX_COMP itself (the "full" state).
  localparam int UW = (MAX_COMP < 1) ? 1 : $clog2(MAX_COMP + 1);

  logic [MSR-1:0]    w_hi;
  logic              w_nonmsr;
  logic              w_accept;
  logic [RW-1:0]     w_row;
  logic              w_last;
  logic              w_comp_req;
  logic              w_has_slot;
  logic              w_take_slot;
  logic [CAW-1:0]    w_caddr;
  logic [31:0]       w_col;

  logic              r_out_valid;
  logic [MSR:0]      r_red;
  logic [AW-1:0]     r_addr;
  logic              r_comp_valid;
  logic [COMP_W-1:0] r_comp_w;
  logic [RW-1:0]     r_comp_row;
  logic [CAW-1:0]    r_comp_addr;
  logic              r_last;
  logic [UW-1:0]     r_used;
  logic [DW-1:0]     r_drop;

  assign w_hi        = weight_in[W-1:MSR];
  // Upper half carrying real magnitude (not just sign extension) forces the MSR path.
  assign w_nonmsr    = (w_hi != '0) && (w_hi != '1);
  assign in_ready    = !r_out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_row       = RW'(32'(addr_in) % SIZE);
  assign w_col       = 32'(addr_in) / SIZE;
  assign w_last      = (w_row == RW'(SIZE - 1));
  assign w_comp_req  = w_nonmsr && !cfg_no_comp;
  assign w_has_slot  = (r_used < UW'(MAX_COMP));
  assign w_take_slot = w_comp_req && w_has_slot;
  assign w_caddr     = CAW'(w_col * MAX_COMP + 32'(r_used));

  // Output register: loads on acceptance, empties on drain, holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_red        <= '0;
      r_addr       <= '0;
      r_comp_valid <= 1'b0;
      r_comp_w     <= '0;
      r_comp_row   <= '0;
      r_comp_addr  <= '0;
      r_last       <= 1'b0;
    end else if (w_accept) begin
      r_out_valid  <= 1'b1;
      r_red        <= w_nonmsr ? {1'b1, w_hi} : {1'b0, weight_in[MSR:1]};
      r_addr       <= addr_in;
      r_last       <= w_last;
      r_comp_valid <= w_take_slot;
      if (w_take_slot) begin
        r_comp_w    <= weight_in[MSR-1:MSR-COMP_W];
        r_comp_row  <= w_row;
        r_comp_addr <= w_caddr;
      end
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
      r_comp_valid <= 1'b0;
    end
  end

  // Column budget and saturating drop counter; the last row may still use the final slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_used <= '0;
      r_drop <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_used <= '0;
      end else if (w_take_slot) begin
        r_used <= r_used + UW'(1);
      end
      if (w_comp_req && !w_has_slot && (r_drop != '1)) begin
        r_drop <= r_drop + DW'(1);
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign reduced_w  = r_red;
  assign addr_out   = r_addr;
  assign comp_valid = r_comp_valid;
  assign comp_w     = r_comp_w;
  assign comp_row   = r_comp_row;
  assign comp_addr  = r_comp_addr;
  assign drop_cnt   = r_drop;
  assign col_done   = r_out_valid && out_ready && r_last;

endmodule

// File: tb/tb_wpu_gen.sv
// Scoreboard bench for wpu_gen: the driver predicts each accepted weight from
// the reduction/budget rules, the monitor pops and compares on every output handshake.
module tb_wpu_gen;
  localparam int SIZE = 8;
  localparam int MAXC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [7:0]  weight_in;
  logic [5:0]  addr_in;
  logic        cfg_no_comp;
  logic        out_valid, out_ready;
  logic [4:0]  reduced_w;
  logic [5:0]  addr_out;
  logic        comp_valid;
  logic [2:0]  comp_w;
  logic [2:0]  comp_row;
  logic [4:0]  comp_addr;
  logic [15:0] drop_cnt;
  logic        col_done;

  wpu_gen dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .weight_in(weight_in), .addr_in(addr_in), .cfg_no_comp(cfg_no_comp),
    .out_valid(out_valid), .out_ready(out_ready), .reduced_w(reduced_w),
    .addr_out(addr_out), .comp_valid(comp_valid), .comp_w(comp_w),
    .comp_row(comp_row), .comp_addr(comp_addr), .drop_cnt(drop_cnt),
    .col_done(col_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  red;
    logic [5:0]  addr;
    logic        cv;
    logic [2:0]  cw;
    logic [2:0]  crow;
    logic [4:0]  caddr;
    logic [15:0] drop;
    logic        last;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  int m_used = 0;
  int m_drop = 0;
  int col_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: per-column budget of MAXC slots, refilled after the last row.
  task automatic model_accept(input logic [7:0] w, input int a, input logic nc);
    exp_t e;
    int hi, row, col;
    bit big;
    hi  = int'(w[7:4]);
    row = a % SIZE;
    col = a / SIZE;
    big = (hi != 0) && (hi != 15);
    e.addr  = 6'(a);
    e.red   = big ? 5'(16 + hi) : 5'(int'(w) / 2 % 16);
    e.cv    = 1'b0;
    e.cw    = 3'(int'(w) / 2 % 8);
    e.crow  = 3'(row);
    e.caddr = 5'(col * MAXC + m_used);
    if (big && !nc) begin
      if (m_used < MAXC) begin
        e.cv = 1'b1;
        m_used++;
      end else if (m_drop < 65535) begin
        m_drop++;
      end
    end
    if (row == SIZE - 1) m_used = 0;
    e.drop = 16'(m_drop);
    e.last = (row == SIZE - 1);
    q.push_back(e);
  endtask

  // Monitor: compare on handshake, check hold stability and stall back-pressure.
  logic        prev_stall = 1'b0;
  logic [4:0]  s_red;
  logic [5:0]  s_addr;
  logic        s_cv;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid) begin
        chk("hold_reduced_w", 32'(reduced_w), 32'(s_red));
        chk("hold_addr_out", 32'(addr_out), 32'(s_addr));
        chk("hold_comp_valid", 32'(comp_valid), 32'(s_cv));
      end
      if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("reduced_w", 32'(reduced_w), 32'(e.red));
          chk("addr_out", 32'(addr_out), 32'(e.addr));
          chk("comp_valid", 32'(comp_valid), 32'(e.cv));
          if (e.cv) begin
            chk("comp_w", 32'(comp_w), 32'(e.cw));
            chk("comp_row", 32'(comp_row), 32'(e.crow));
            chk("comp_addr", 32'(comp_addr), 32'(e.caddr));
          end
          chk("drop_cnt", 32'(drop_cnt), 32'(e.drop));
          chk("col_done", 32'(col_done), 32'(e.last));
          if (col_done) col_pulses++;
        end
      end else begin
        chk("col_done_idle", 32'(col_done), 32'd0);
      end
      prev_stall = out_valid && !out_ready;
      s_red  = reduced_w;
      s_addr = addr_out;
      s_cv   = comp_valid;
    end
  end

  // One clock: apply inputs, note acceptance at the falling edge, return just after the rising edge.
  task automatic cyc(input logic v, input logic [7:0] w, input int a, input logic nc,
                     input logic ordy, output bit acc);
    in_valid    = v;
    weight_in   = w;
    addr_in     = 6'(a);
    cfg_no_comp = nc;
    out_ready   = ordy;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (acc) model_accept(w, a, nc);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] w, input int a, input logic nc, input int rdy_pct);
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++)
      cyc(1'b1, w, a, nc, ($urandom_range(99) < rdy_pct), acc);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit acc;
    for (int k = 0; k < 30 && q.size() != 0; k++) cyc(1'b0, 8'h00, 0, 1'b0, 1'b1, acc);
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    q.delete();
    m_used = 0;
    m_drop = 0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_comp_valid", 32'(comp_valid), 32'd0);
      chk("rst_col_done", 32'(col_done), 32'd0);
      chk("rst_reduced_w", 32'(reduced_w), 32'd0);
      chk("rst_addr_out", 32'(addr_out), 32'd0);
      chk("rst_comp_fields", {21'd0, comp_w, comp_row, comp_addr}, 32'd0);
      chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit acc;
    int a;
    rst = 1'b1;
    in_valid = 1'b0;
    weight_in = '0;
    addr_in = '0;
    cfg_no_comp = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Column 0: compensated, low-field, all-ones, suppressed, then plain rows.
    send(8'hB6, 0, 1'b0, 100);
    send(8'h0A, 1, 1'b0, 100);
    send(8'hF3, 2, 1'b0, 100);
    send(8'hB6, 3, 1'b1, 100);
    for (int r = 4; r < SIZE; r++) send(8'h0A, r, 1'b0, 100);
    drain();
    chk("suppressed_no_drop", 32'(drop_cnt), 32'd0);

    // Column 1 all compensable: three slots, five drops, one col_done.
    col_pulses = 0;
    for (int r = 0; r < SIZE; r++) send(8'hB6, SIZE + r, 1'b0, 100);
    drain();
    chk("col1_drop_cnt", 32'(drop_cnt), 32'd5);
    chk("col1_done_pulses", 32'(col_pulses), 32'd1);

    // Back-pressure: new weight held for three stalled cycles.
    cyc(1'b1, 8'hB6, 16, 1'b0, 1'b1, acc);
    for (int k = 0; k < 3; k++) cyc(1'b1, 8'h0A, 17, 1'b0, 1'b0, acc);
    send(8'h0A, 17, 1'b0, 100);
    drain();

    // Mid-stream reset after two compensations restarts the budget and drop count.
    send(8'hB6, 0, 1'b0, 100);
    send(8'hB6, 1, 1'b0, 100);
    do_reset();
    send(8'hB6, 0, 1'b0, 100);
    drain();
    chk("post_rst_drop_cnt", 32'(drop_cnt), 32'd0);

    // Randomized traffic with random back-pressure.
    a = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) a = $urandom_range(63);
      else a = (a + 1) % 64;
      send(8'($urandom), a, ($urandom_range(9) == 0), 70);
      if ($urandom_range(7) == 0) cyc(1'b0, 8'h00, 0, 1'b0, $urandom_range(1), acc);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
